// File: rtl/truth_table_sweeper_if.sv
// Sweeper control, result and gate-drive signals.
// Master is the test environment, slave is the sweeper.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int W  = 2 ** N_IN;
  localparam int CW = $clog2(W + 1);

  logic            start;
  logic            abort;
  logic [W-1:0]    expected;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic [W-1:0]    table_code;
  logic            match;
  logic [CW-1:0]   mismatch_cnt;

  modport master (
    output start, abort, expected, dut_out,
    input  dut_in, busy, done,
    input  table_code, match, mismatch_cnt
  );

  modport slave (
    input  start, abort, expected, dut_out,
    output dut_in, busy, done,
    output table_code, match, mismatch_cnt
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a gate, rebuilds its
// truth-table code and compares it to an expected code.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input logic clk,
  input logic rst_n,
  truth_table_sweeper_if.slave bus
);
  localparam int W  = 2 ** N_IN;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state;
  state_t          state_nx;
  logic [7:0]      hold_cnt;
  logic [N_IN-1:0] vec;
  logic [W-1:0]    exp_q;
  logic [W-1:0]    work_code;
  logic [W-1:0]    code_nx;
  logic [CW-1:0]   work_cnt;
  logic [CW-1:0]   cnt_nx;
  logic [N_IN-1:0] bit_idx;
  logic            accept;
  logic            sample;
  logic            last;
  logic            diff;
  logic            done_q;
  logic [W-1:0]    pub_code;
  logic            pub_match;
  logic [CW-1:0]   pub_cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: abort dominates both start and completion
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = HOLD;
      HOLD: if (bus.abort || last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control strobes and the code/count after this sample
  always_comb begin
    accept  = (state == IDLE) && bus.start && !bus.abort;
    sample  = (state == HOLD) && (hold_cnt == 8'(SETTLE));
    last    = sample && (vec == '1);
    bit_idx = ~vec;
    diff    = bus.dut_out ^ exp_q[bit_idx];
    code_nx = work_code;
    code_nx[bit_idx] = bus.dut_out;
    cnt_nx  = work_cnt + CW'(diff);
  end

  // Vector stepping, sampling and result publishing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      vec       <= '0;
      exp_q     <= '0;
      work_code <= '0;
      work_cnt  <= '0;
      done_q    <= 1'b0;
      pub_code  <= '0;
      pub_match <= 1'b0;
      pub_cnt   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        hold_cnt  <= '0;
        vec       <= '0;
        exp_q     <= bus.expected;
        work_code <= '0;
        work_cnt  <= '0;
      end else if (state == HOLD) begin
        if (bus.abort) begin
          vec <= '0;
        end else if (sample) begin
          hold_cnt  <= '0;
          work_code <= code_nx;
          work_cnt  <= cnt_nx;
          if (last) begin
            vec       <= '0;
            done_q    <= 1'b1;
            pub_code  <= code_nx;
            pub_match <= (code_nx == exp_q);
            pub_cnt   <= cnt_nx;
          end else begin
            vec <= vec + 1'b1;
          end
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.dut_in       = vec;
  assign bus.busy         = (state == HOLD);
  assign bus.done         = done_q;
  assign bus.table_code   = pub_code;
  assign bus.match        = pub_match;
  assign bus.mismatch_cnt = pub_cnt;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: vector table,
// done-driven scoreboard and corner-case sequences.
module tb_truth_table_sweeper;
  typedef struct {
    int         mode;
    logic [7:0] exp;
    logic [7:0] code;
    logic       mtch;
    logic [3:0] cnt;
  } vec_t;

  typedef struct {
    logic [7:0] code;
    logic       mtch;
    logic [3:0] cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mode = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  res_t sb[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) bus ();
  truth_table_sweeper_if #(.N_IN(2)) bus2 ();

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  function automatic logic gate(int m, logic [2:0] v);
    case (m)
      0: return (v == 3'd1) || (v == 3'd2) || (v == 3'd7);
      1: return 1'b1;
      3: return &v;
      4: return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
      default: return 1'b0;
    endcase
  endfunction

  always_comb bus.dut_out = gate(mode, bus.dut_in);
  always_comb bus2.dut_out = ^bus2.dut_in;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Edge counter and acceptance edge of the latest sweep
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.start && !bus.abort && !bus.busy)
      acc_cyc <= cyc + 1;
  end

  // Scoreboard: compare each completed sweep
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      res_t e;
      done_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("table_code", 32'(bus.table_code), 32'(e.code));
        chk("match", 32'(bus.match), 32'(e.mtch));
        chk("mismatch_cnt", 32'(bus.mismatch_cnt), 32'(e.cnt));
        chk("latency", 32'(cyc - acc_cyc), 32'd24);
      end
    end
  end

  task automatic start_pulse(logic [7:0] e);
    @(negedge clk);
    bus.expected = e;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(int target);
    for (int k = 0; k < 200 && done_seen < target; k++)
      @(negedge clk);
    chk("done_timeout", 32'(done_seen >= target), 1);
    if (done_seen < target) sb.delete();
  endtask

  task automatic push(logic [7:0] c, logic m, logic [3:0] n);
    res_t r;
    r.code = c;
    r.mtch = m;
    r.cnt = n;
    sb.push_back(r);
  endtask

  initial begin
    int d0;
    int n;
    tbl[0] = '{0, 8'h61, 8'h61, 1'b1, 4'd0};
    tbl[1] = '{0, 8'h60, 8'h61, 1'b0, 4'd1};
    tbl[2] = '{1, 8'h00, 8'hFF, 1'b0, 4'd8};
    tbl[3] = '{3, 8'h01, 8'h01, 1'b1, 4'd0};
    tbl[4] = '{4, 8'h17, 8'h17, 1'b1, 4'd0};
    tbl[5] = '{1, 8'hFF, 8'hFF, 1'b1, 4'd0};

    bus.start = 0;
    bus.abort = 0;
    bus.expected = 0;
    bus2.start = 0;
    bus2.abort = 0;
    bus2.expected = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_dut_in", 32'(bus.dut_in), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_code", 32'(bus.table_code), 0);
    chk("rst_match", 32'(bus.match), 0);
    chk("rst_cnt", 32'(bus.mismatch_cnt), 0);

    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      push(tbl[i].code, tbl[i].mtch, tbl[i].cnt);
      d0 = done_seen;
      start_pulse(tbl[i].exp);
      wait_done(d0 + 1);
    end

    // Abort mid-sweep
    mode = 0;
    d0 = done_seen;
    start_pulse(8'h61);
    repeat (9) @(posedge clk);
    #1 chk("abort_busy_before", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_dut_in", 32'(bus.dut_in), 0);
    repeat (40) @(posedge clk);
    #1 chk("abort_no_done", 32'(done_seen), 32'(d0));
    chk("abort_code_kept", 32'(bus.table_code), 32'h FF);

    // Abort together with start in IDLE
    @(negedge clk);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_idle", 32'(bus.busy), 0);

    // Restart; a second start while busy is ignored
    push(8'h61, 1'b1, 4'd0);
    d0 = done_seen;
    start_pulse(8'h61);
    repeat (5) @(posedge clk);
    start_pulse(8'h00);
    #1 chk("code_held_busy", 32'(bus.table_code), 32'h FF);
    wait_done(d0 + 1);

    // Abort on the completion edge
    mode = 1;
    d0 = done_seen;
    start_pulse(8'hFF);
    repeat (23) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    chk("abort_last_done", 32'(bus.done), 0);
    chk("abort_last_busy", 32'(bus.busy), 0);
    chk("abort_last_code", 32'(bus.table_code), 32'h61);
    repeat (5) @(posedge clk);
    #1 chk("abort_last_none", 32'(done_seen), 32'(d0));

    // Reset mid-sweep
    mode = 0;
    start_pulse(8'h60);
    repeat (5) @(posedge clk);
    #1 chk("mid_dut_in", 32'(bus.dut_in), 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mrst_dut_in", 32'(bus.dut_in), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_code", 32'(bus.table_code), 0);
    chk("mrst_match", 32'(bus.match), 0);
    chk("mrst_cnt", 32'(bus.mismatch_cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    push(8'h61, 1'b0, 4'd1);
    d0 = done_seen;
    start_pulse(8'h60);
    chk("post_rst_dut_in", 32'(bus.dut_in), 0);
    chk("post_rst_busy", 32'(bus.busy), 1);
    wait_done(d0 + 1);

    // Start held high: back-to-back sweeps
    repeat (3) push(8'h61, 1'b1, 4'd0);
    @(negedge clk);
    bus.expected = 8'h61;
    bus.start = 1'b1;
    n = 0;
    for (int k = 0; k < 200 && n < 3; k++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    bus.start = 1'b0;
    chk("b2b_count", 32'(n), 3);
    repeat (30) @(posedge clk);
    #1 chk("b2b_idle", 32'(bus.busy), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    // Two-input XOR, no settle cycles
    @(negedge clk);
    bus2.expected = 4'b0110;
    bus2.start = 1'b1;
    @(posedge clk);
    #1 bus2.start = 1'b0;
    chk("x_dut_in0", 32'(bus2.dut_in), 0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1 chk("x_dut_in_step", 32'(bus2.dut_in), 32'(i));
    end
    @(posedge clk);
    #1 chk("x_done", 32'(bus2.done), 1);
    chk("x_code", 32'(bus2.table_code), 32'b0110);
    chk("x_match", 32'(bus2.match), 1);
    chk("x_cnt", 32'(bus2.mismatch_cnt), 0);
    chk("x_dut_in_end", 32'(bus2.dut_in), 0);
    @(posedge clk);
    #1 chk("x_done_pulse", 32'(bus2.done), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
